retire_tracer: RTL and testbench

RETIRE_TRACER -- requirements
Module: retire_tracer

---
 rtl/retire_trace_pkg.sv | 25 ++
 rtl/trace_fifo.sv | 64 ++++++
 rtl/retire_tracer.sv | 135 +++++++++++++
 tb/tb_retire_tracer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/retire_trace_pkg.sv
// Shared types and constants for the retire tracer.
// The seq field exists only when RETIRE_TRACE_SEQ_EN is defined.
package retire_trace_pkg;

  localparam int unsigned TRACE_XLEN_MAX  = 64;
  localparam int unsigned TRACE_DEPTH_DEF = 8;
  localparam int unsigned DROP_CNT_W      = 16;
  localparam int unsigned SEQ_W           = 16;
  localparam int unsigned REG_ADDR_W      = 5;

  // Fields are sized for the widest supported XLEN; narrower builds zero-extend.
  typedef struct packed {
`ifdef RETIRE_TRACE_SEQ_EN
    logic [SEQ_W-1:0]          seq;
`endif
    logic [TRACE_XLEN_MAX-1:0] pc;
    logic [TRACE_XLEN_MAX-1:0] instr;
    logic [REG_ADDR_W-1:0]     rd;
    logic [TRACE_XLEN_MAX-1:0] rd_data;
    logic                      st;
    logic [TRACE_XLEN_MAX-1:0] st_addr;
    logic [TRACE_XLEN_MAX-1:0] st_data;
  } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Record FIFO with a registered head stage: valid follows a push by one cycle
// and the next head is preloaded so back-to-back pops never bubble.
module trace_fifo #(
  parameter type         rec_t = logic [7:0],
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  rec_t                   wdata,
  input  logic                   ready,
  output logic                   valid,
  output rec_t                   head,
  output logic [$clog2(DEPTH):0] level,
  output logic                   drop_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  rec_t             mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_n, wr_n;
  logic [LVL_W-1:0] cnt_n;
  logic             pop_c, full, do_push;
  rec_t             head_n;

  // A push into a full FIFO is only accepted when the head pops in the same cycle.
  always_comb begin
    head_n  = '0;
    pop_c   = valid & ready;
    full    = (level == LVL_W'(DEPTH));
    do_push = push & (~full | pop_c);
    drop_c  = push & full & ~pop_c;
    rd_n    = rd_ptr + PTR_W'(pop_c);
    wr_n    = wr_ptr + PTR_W'(do_push);
    cnt_n   = level + LVL_W'(do_push) - LVL_W'(pop_c);
    if (cnt_n != '0) begin
      head_n = (do_push && (wr_ptr == rd_n)) ? wdata : mem[rd_n];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      valid  <= 1'b0;
      head   <= '0;
    end else begin
      rd_ptr <= rd_n;
      wr_ptr <= wr_n;
      level  <= cnt_n;
      valid  <= (cnt_n != '0);
      head   <= head_n;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/retire_tracer.sv
// Retire tracer: folds data-memory stores into the next retired record and queues records.
// Define RETIRE_TRACE_SEQ_EN to add a per-record sequence number on trace_seq_o.
module retire_tracer
  import retire_trace_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = TRACE_DEPTH_DEF
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   update_i,
  input  logic [XLEN-1:0]        pc_i,
  input  logic [XLEN-1:0]        instr_i,
  input  logic [REG_ADDR_W-1:0]  reg_addr_i,
  input  logic [XLEN-1:0]        reg_data_i,
  input  logic                   mem_wrt_i,
  input  logic [XLEN-1:0]        mem_addr_i,
  input  logic [XLEN-1:0]        mem_data_i,
  output logic                   trace_valid_o,
  input  logic                   trace_ready_i,
  output logic [XLEN-1:0]        trace_pc_o,
  output logic [XLEN-1:0]        trace_instr_o,
  output logic [REG_ADDR_W-1:0]  trace_rd_o,
  output logic [XLEN-1:0]        trace_rd_data_o,
  output logic                   trace_st_o,
  output logic [XLEN-1:0]        trace_st_addr_o,
  output logic [XLEN-1:0]        trace_st_data_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   overflow_o,
  output logic [DROP_CNT_W-1:0]  drop_cnt_o
`ifdef RETIRE_TRACE_SEQ_EN
  ,
  output logic [SEQ_W-1:0]       trace_seq_o
`endif
);

  trace_rec_t      rec;
  trace_rec_t      head;
  logic            st_pend;
  logic [XLEN-1:0] st_addr, st_data;
  logic            drop_c;
  logic            unused_head;

  // Pending store slot; every update consumes it.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      st_pend <= 1'b0;
      st_addr <= '0;
      st_data <= '0;
    end else if (update_i) begin
      st_pend <= 1'b0;
      st_addr <= '0;
      st_data <= '0;
    end else if (mem_wrt_i) begin
      st_pend <= 1'b1;
      st_addr <= mem_addr_i;
      st_data <= mem_data_i;
    end
  end

`ifdef RETIRE_TRACE_SEQ_EN
  logic [SEQ_W-1:0] seq;

  // Counts every update, dropped ones included, so gaps reveal drops.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      seq <= '0;
    end else if (update_i) begin
      seq <= seq + SEQ_W'(1);
    end
  end

  assign trace_seq_o = head.seq;
`endif

  // A same-cycle store takes priority over an older pending one.
  always_comb begin
    rec         = '0;
    rec.pc      = TRACE_XLEN_MAX'(pc_i);
    rec.instr   = TRACE_XLEN_MAX'(instr_i);
    rec.rd      = reg_addr_i;
    rec.rd_data = TRACE_XLEN_MAX'(reg_data_i);
    if (mem_wrt_i) begin
      rec.st      = 1'b1;
      rec.st_addr = TRACE_XLEN_MAX'(mem_addr_i);
      rec.st_data = TRACE_XLEN_MAX'(mem_data_i);
    end else if (st_pend) begin
      rec.st      = 1'b1;
      rec.st_addr = TRACE_XLEN_MAX'(st_addr);
      rec.st_data = TRACE_XLEN_MAX'(st_data);
    end
`ifdef RETIRE_TRACE_SEQ_EN
    rec.seq = seq;
`endif
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (drop_c) begin
      overflow_o <= 1'b1;
      if (drop_cnt_o != '1) begin
        drop_cnt_o <= drop_cnt_o + DROP_CNT_W'(1);
      end
    end
  end

  trace_fifo #(
    .rec_t (trace_rec_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk_i),
    .rst_n  (rstn_i),
    .push   (update_i),
    .wdata  (rec),
    .ready  (trace_ready_i),
    .valid  (trace_valid_o),
    .head   (head),
    .level  (level_o),
    .drop_c (drop_c)
  );

  assign trace_pc_o      = XLEN'(head.pc);
  assign trace_instr_o   = XLEN'(head.instr);
  assign trace_rd_o      = head.rd;
  assign trace_rd_data_o = XLEN'(head.rd_data);
  assign trace_st_o      = head.st;
  assign trace_st_addr_o = XLEN'(head.st_addr);
  assign trace_st_data_o = XLEN'(head.st_data);

  // Bits above XLEN are constant zero.
  assign unused_head = ^{head.pc, head.instr, head.rd_data, head.st_addr, head.st_data};

endmodule

// File: tb/tb_retire_tracer.sv
// Directed self-checking bench for retire_tracer (DEPTH 8, XLEN 32).
// Sequence-number checks are active when RETIRE_TRACE_SEQ_EN is defined.
module tb_retire_tracer;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 8;

  logic            clk = 1'b0;
  logic            rstn;
  logic            update;
  logic [XLEN-1:0] pc, instr, reg_data, mem_addr, mem_data;
  logic [4:0]      reg_addr;
  logic            mem_wrt;
  logic            ready;
  logic            t_valid, t_st, overflow;
  logic [XLEN-1:0] t_pc, t_instr, t_rd_data, t_st_addr, t_st_data;
  logic [4:0]      t_rd;
  logic [3:0]      level;
  logic [15:0]     drop_cnt;
`ifdef RETIRE_TRACE_SEQ_EN
  logic [15:0]     t_seq;
`endif

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  retire_tracer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .update_i        (update),
    .pc_i            (pc),
    .instr_i         (instr),
    .reg_addr_i      (reg_addr),
    .reg_data_i      (reg_data),
    .mem_wrt_i       (mem_wrt),
    .mem_addr_i      (mem_addr),
    .mem_data_i      (mem_data),
    .trace_valid_o   (t_valid),
    .trace_ready_i   (ready),
    .trace_pc_o      (t_pc),
    .trace_instr_o   (t_instr),
    .trace_rd_o      (t_rd),
    .trace_rd_data_o (t_rd_data),
    .trace_st_o      (t_st),
    .trace_st_addr_o (t_st_addr),
    .trace_st_data_o (t_st_data),
    .level_o         (level),
    .overflow_o      (overflow),
    .drop_cnt_o      (drop_cnt)
`ifdef RETIRE_TRACE_SEQ_EN
    ,
    .trace_seq_o     (t_seq)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] p, input logic [31:0] ins,
                        input logic [4:0] rd, input logic [31:0] d);
    update   = 1'b1;
    pc       = p;
    instr    = ins;
    reg_addr = rd;
    reg_data = d;
    tick();
    update   = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; update = 1'b0; pc = '0; instr = '0; reg_addr = '0; reg_data = '0;
    mem_wrt = 1'b0; mem_addr = '0; mem_data = '0; ready = 1'b0;
    repeat (3) tick();
    check("rst_valid", 64'(t_valid), 64'h0);
    check("rst_level", 64'(level), 64'h0);
    check("rst_overflow", 64'(overflow), 64'h0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'h0);
    check("rst_pc", 64'(t_pc), 64'h0);
    rstn = 1'b1;
    tick();

    // Test 1: single retire, consumer ready
    ready = 1'b1;
    retire(32'h0000_0010, 32'h0050_0093, 5'd1, 32'd5);
    check("t1_valid", 64'(t_valid), 64'h1);
    check("t1_pc", 64'(t_pc), 64'h10);
    check("t1_instr", 64'(t_instr), 64'h0050_0093);
    check("t1_rd", 64'(t_rd), 64'h1);
    check("t1_rd_data", 64'(t_rd_data), 64'h5);
    check("t1_st", 64'(t_st), 64'h0);
    check("t1_level", 64'(level), 64'h1);
`ifdef RETIRE_TRACE_SEQ_EN
    check("t1_seq", 64'(t_seq), 64'h0);
`endif
    tick();
    check("t1_level_after_pop", 64'(level), 64'h0);
    check("t1_valid_after_pop", 64'(t_valid), 64'h0);

    // Test 2: store two cycles ahead of the update
    ready = 1'b0;
    mem_wrt = 1'b1; mem_addr = 32'h100; mem_data = 32'hDEAD_BEEF;
    tick();
    mem_wrt = 1'b0;
    check("t2_store_no_record", 64'(level), 64'h0);
    tick();
    retire(32'h14, 32'h0011_2023, 5'd0, 32'h0);
    retire(32'h18, 32'h0000_0013, 5'd0, 32'h0);
    check("t2_level", 64'(level), 64'h2);
    check("t2_st", 64'(t_st), 64'h1);
    check("t2_st_addr", 64'(t_st_addr), 64'h100);
    check("t2_st_data", 64'(t_st_data), 64'hDEAD_BEEF);
    ready = 1'b1;
    tick();
    check("t2_next_pc", 64'(t_pc), 64'h18);
    check("t2_next_st", 64'(t_st), 64'h0);
    check("t2_next_st_addr", 64'(t_st_addr), 64'h0);
    check("t2_next_st_data", 64'(t_st_data), 64'h0);
    tick();
    check("t2_drained", 64'(level), 64'h0);

    // Test 3: same-cycle store overrides an older pending one
    ready = 1'b0;
    mem_wrt = 1'b1; mem_addr = 32'h200; mem_data = 32'h1111_1111;
    tick();
    mem_addr = 32'h300; mem_data = 32'h2222_2222;
    retire(32'h1C, 32'h0000_0013, 5'd2, 32'h7);
    mem_wrt = 1'b0;
    check("t3_st", 64'(t_st), 64'h1);
    check("t3_st_addr", 64'(t_st_addr), 64'h300);
    check("t3_st_data", 64'(t_st_data), 64'h2222_2222);
    retire(32'h20, 32'h0000_0013, 5'd3, 32'h8);
    ready = 1'b1;
    tick();
    check("t3_next_pc", 64'(t_pc), 64'h20);
    check("t3_next_st", 64'(t_st), 64'h0);
    check("t3_next_st_addr", 64'(t_st_addr), 64'h0);
    tick();
    ready = 1'b0;

    // Test 4: overflow with consumer stalled, then in-order drain
    for (int i = 0; i < int'(DEPTH) + 3; i++) begin
      retire(32'(32'h1000 + 4 * i), 32'h0000_0013, 5'd4, 32'(i));
    end
    check("t4_level", 64'(level), 64'(DEPTH));
    check("t4_overflow", 64'(overflow), 64'h1);
    check("t4_drop_cnt", 64'(drop_cnt), 64'h3);
    check("t4_head_pc", 64'(t_pc), 64'h1000);
`ifdef RETIRE_TRACE_SEQ_EN
    check("t4_head_seq", 64'(t_seq), 64'd5);
`endif
    tick();
    check("t4_head_stable", 64'(t_pc), 64'h1000);
    ready = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      check("t4_drain_pc", 64'(t_pc), 64'(32'h1000 + 4 * i));
      check("t4_drain_rd_data", 64'(t_rd_data), 64'(i));
      tick();
    end
    check("t4_empty_level", 64'(level), 64'h0);
    check("t4_empty_valid", 64'(t_valid), 64'h0);
    ready = 1'b0;

    // Test 5: full FIFO with simultaneous push and pop
    for (int i = 0; i < int'(DEPTH); i++) begin
      retire(32'(32'h3000 + 4 * i), 32'h0000_0013, 5'd5, 32'h0);
    end
    check("t5_full_level", 64'(level), 64'(DEPTH));
    check("t5_full_drop_cnt", 64'(drop_cnt), 64'h3);
    ready = 1'b1;
    retire(32'h3020, 32'h0000_0013, 5'd5, 32'h0);
    check("t5_level", 64'(level), 64'(DEPTH));
    check("t5_drop_cnt", 64'(drop_cnt), 64'h3);
    check("t5_head_pc", 64'(t_pc), 64'h3004);
    check("t5_overflow_sticky", 64'(overflow), 64'h1);
    repeat (4) tick();
    check("t5_level_4", 64'(level), 64'h4);
    check("t5_head_pc_4", 64'(t_pc), 64'h3014);
`ifdef RETIRE_TRACE_SEQ_EN
    check("t5_head_seq", 64'(t_seq), 64'd21);
`endif
    ready = 1'b0;

    // Test 6: reset mid-stream with 4 records and a pending store
    mem_wrt = 1'b1; mem_addr = 32'h500; mem_data = 32'h55;
    tick();
    mem_wrt = 1'b0;
    rstn = 1'b0;
    #1;
    check("t6_valid", 64'(t_valid), 64'h0);
    check("t6_level", 64'(level), 64'h0);
    check("t6_overflow", 64'(overflow), 64'h0);
    check("t6_drop_cnt", 64'(drop_cnt), 64'h0);
    check("t6_pc", 64'(t_pc), 64'h0);
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    retire(32'h4000, 32'h0000_0013, 5'd6, 32'h9);
    check("t6_post_valid", 64'(t_valid), 64'h1);
    check("t6_post_pc", 64'(t_pc), 64'h4000);
    check("t6_post_st", 64'(t_st), 64'h0);
    check("t6_post_st_addr", 64'(t_st_addr), 64'h0);
    check("t6_post_level", 64'(level), 64'h1);
`ifdef RETIRE_TRACE_SEQ_EN
    check("t6_post_seq", 64'(t_seq), 64'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
